router_out_arb: RTL
===================

ROUTER_OUT_ARB -- requirements
Module: router_out_arb

Interface
REQ-001 The block SHALL have parameter CREDITS, default 4, meaning the downstream buffer depth in flits (legal range 1..7).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port req_i  input  5  per-input-port flit-ready requests, with bit 0 = north, 1 = south, 2 = east, 3 = west, 4 = local.
REQ-005 The block SHALL have port flit_i  input  80  five 16-bit flits, with flit of port k at bits [16k+15:16k].
REQ-006 The block SHALL have port incr_i  input  1  downstream credit return, one credit per cycle asserted.
REQ-007 The block SHALL have port gnt_o  output  5  one-hot or zero grant; combinational; the input buffer pops its flit in the same cycle.
REQ-008 The block SHALL have port flit_o  output  16  registered output flit.
REQ-009 The block SHALL have port valid_o  output  1  registered, and flit_o is valid this cycle.
REQ-010 The block SHALL have port credit_o  output  3  current credit count.
REQ-011 The block SHALL have port credit_err_o  output  1  sticky credit-overflow flag.

Function
REQ-012 The flit type SHALL be flit[15:14]: 2'b10 head, 2'b00 body, 2'b01 tail, 2'b11 single (head plus tail).
REQ-013 A grant SHALL be issued only when credit_o > 0; at most one gnt_o bit SHALL be high per cycle.
REQ-014 The FSM SHALL have two states: IDLE (output free) and LOCKED (a wormhole packet owns the output, with owner index held in register).
REQ-015 In IDLE, eligible requesters SHALL be those with req_i high and flit type head or single; body and tail flits SHALL be ignored.
REQ-016 In IDLE, the winner SHALL be the first eligible port scanning from rr_ptr upward, modulo 5.
REQ-017 IDLE with a head granted SHALL transition to LOCKED with owner set to the winner.
REQ-018 IDLE with a single granted SHALL remain in IDLE.
REQ-019 In LOCKED, only the owner SHALL be granted, when req_i[owner] is high and credit_o > 0; other ports' requests SHALL be ignored.
REQ-020 In LOCKED, a granted tail SHALL return the FSM to IDLE; a granted body or head SHALL keep it LOCKED.
REQ-021 On each packet completion (single grant or tail grant), rr_ptr SHALL be set to (winner+1) mod 5; rr_ptr SHALL not change otherwise.
REQ-022 The granted flit SHALL appear on flit_o with valid_o=1 in the cycle after the grant (latency 1); with no grant, valid_o=0 and flit_o SHALL hold its value.
REQ-023 Credit update: a grant alone SHALL decrement the credit count by 1, incr_i alone SHALL increment it by 1, and both in the same cycle SHALL leave it unchanged.
REQ-024 incr_i alone at credit_o == CREDITS SHALL saturate the count at CREDITS and set credit_err_o, which SHALL remain set until reset.
REQ-025 Back-to-back grants SHALL be allowed every cycle while credit lasts.
REQ-026 A zero-credit stall mid-packet SHALL keep the state LOCKED and the owner unchanged.

Reset
REQ-027 While rst=1 at a clock edge, the next state SHALL be: FSM in IDLE, owner 0, rr_ptr 0 (north), credit_o = CREDITS, valid_o 0, flit_o 16'h0000, credit_err_o 0; gnt_o SHALL be 0 while rst is high.
REQ-028 Reset asserted mid-packet SHALL abandon the packet with no further grants to the old owner; any partial-packet recovery is upstream's responsibility.

Verification
REQ-029 Reset, then all five ports present singles each cycle with incr_i tied high -> grants SHALL rotate N,S,E,W,L,N; valid_o SHALL be high every cycle from the 2nd cycle; credit_o SHALL stay at 4.
REQ-030 East sends head, body, tail while north holds a head -> grants SHALL go E,E,E, then N; flit_o SHALL be 3 east flits, then north's head.
REQ-031 CREDITS=4, incr_i=0, local streams 6 body-after-head flits -> 4 grants, then gnt_o=0 with credit_o=0; one incr_i pulse -> exactly one more local grant.
REQ-032 Grant and incr_i in the same cycle at credit_o=2 -> credit_o SHALL remain 2.
REQ-033 With credit_o=4 and incr_i=1 for one cycle -> credit_o SHALL stay 4 and credit_err_o SHALL go 1 and stay 1 until rst.
REQ-034 rst during LOCKED owned by west -> next cycle the FSM SHALL be IDLE, and a south single with a west body SHALL grant south only.

Source files
------------

// File: rtl/router_out_arb.sv
// Output-port arbiter for a wormhole router: round-robin packet arbitration,
// wormhole locking to the packet owner, and credit-based downstream flow control.
//
// Handshake: gnt_o[k] is combinational and means "port k's flit is consumed
// this cycle"; the input buffer pops on gnt_o alone (no ready back-pressure).
// The granted flit is presented one cycle later on flit_o with valid_o=1.
module router_out_arb #(
    parameter int CREDITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  req_i,
    input  logic [79:0] flit_i,
    input  logic        incr_i,
    output logic [4:0]  gnt_o,
    output logic [15:0] flit_o,
    output logic        valid_o,
    output logic [2:0]  credit_o,
    output logic        credit_err_o,
    output logic        dbg_state,
    output logic [2:0]  dbg_owner,
    output logic [2:0]  dbg_rr
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [2:0] CRED_MAX = 3'(CREDITS);

    state_t      state;
    logic [2:0]  owner;
    logic [2:0]  rr_ptr;
    logic [4:0]  eligible;
    logic [2:0]  win;
    logic [3:0]  idx;
    logic        found;
    logic        any_gnt;
    logic [15:0] win_flit;

    function automatic logic [2:0] next_port(input logic [2:0] p);
        return (p == 3'd4) ? 3'd0 : p + 3'd1;
    endfunction

    // Only head (10) and single (11) flits may open a packet; bit 15 marks both.
    always_comb begin
        eligible = '0;
        for (int k = 0; k < 5; k++) begin
            eligible[k] = req_i[k] & flit_i[16*k+15];
        end
        found = 1'b0;
        win   = 3'd0;
        idx   = 4'd0;
        if (state == LOCKED) begin
            win   = owner;
            found = req_i[owner];
        end else begin
            for (int i = 0; i < 5; i++) begin
                idx = {1'b0, rr_ptr} + 4'(i);
                if (idx >= 4'd5) idx = idx - 4'd5;
                if (!found && eligible[idx[2:0]]) begin
                    found = 1'b1;
                    win   = idx[2:0];
                end
            end
        end
        any_gnt = found && (credit_o != 3'd0) && !rst;
        gnt_o   = '0;
        if (any_gnt) gnt_o[win] = 1'b1;
    end

    assign win_flit  = flit_i[{win, 4'b0000} +: 16];
    assign dbg_state = (state == LOCKED);
    assign dbg_owner = owner;
    assign dbg_rr    = rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= 3'd0;
            rr_ptr       <= 3'd0;
            credit_o     <= CRED_MAX;
            valid_o      <= 1'b0;
            flit_o       <= 16'h0000;
            credit_err_o <= 1'b0;
        end else begin
            valid_o <= any_gnt;
            if (any_gnt) flit_o <= win_flit;

            // Simultaneous grant and return cancel out.
            case ({any_gnt, incr_i})
                2'b10: credit_o <= credit_o - 3'd1;
                2'b01: begin
                    if (credit_o == CRED_MAX) credit_err_o <= 1'b1;
                    else                      credit_o     <= credit_o + 3'd1;
                end
                default: credit_o <= credit_o;
            endcase

            // Bit 14 is set for tail and single: either one closes the packet.
            case (state)
                IDLE: begin
                    if (any_gnt) begin
                        if (win_flit[14]) begin
                            rr_ptr <= next_port(win);
                        end else begin
                            state <= LOCKED;
                            owner <= win;
                        end
                    end
                end
                LOCKED: begin
                    if (any_gnt && win_flit[14]) begin
                        state  <= IDLE;
                        rr_ptr <= next_port(owner);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
